// File: rtl/counter_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for debounced_event_counter:
//   - edge_mode_e : which debounced transitions are counted
//   - db_state_e  : per-channel debounce FSM states
//   - edge_qualify: folds rise/fall pulses and the edge mode into one count pulse
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        DB_STABLE = 1'b0,   // synchronised input agrees with the accepted level
        DB_CHECK  = 1'b1    // input disagrees; timing how long it stays that way
    } db_state_e;

    function automatic logic edge_qualify(input edge_mode_e mode,
                                          input logic       rise,
                                          input logic       fall);
        logic hit;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage : counter_pkg

// File: rtl/debounce_channel.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// debounce_channel
// One input channel: SYNC_STAGES-flop synchroniser, then a STABLE/CHECK FSM
// that accepts a new level only after STABLE_CYCLES consecutive mismatching
// synchronised samples. Emits one-clock rise/fall pulses, aligned with the
// cycle in which the new level first appears on `level`.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   inp   in  raw asynchronous, bouncy input
//   level out debounced level
//   rise  out one-clock pulse when level went 0->1
//   fall  out one-clock pulse when level went 1->0
// -----------------------------------------------------------------------------
module debounce_channel
    import counter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic level,
    output logic rise,
    output logic fall
);

    // Wide enough to hold STABLE_CYCLES itself, so STABLE_CYCLES=1 still gets a bit.
    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle;

    assign s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; the sync chain depends on it.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], inp};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (s != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        // A single mismatching sample is already a full window.
                        toggle = 1'b1;
                    end else begin
                        state_d = DB_CHECK;
                        cnt_d   = CW'(1);
                    end
                end
            end
            DB_CHECK: begin
                if (s == level_q) begin
                    // Input fell back before the window elapsed: a glitch.
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    toggle  = 1'b1;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        level_d = level_q ^ toggle;
        rise_d  = toggle & ~level_q;
        fall_d  = toggle &  level_q;
    end

    // Outputs
    always_comb begin
        level = level_q;
        rise  = rise_q;
        fall  = fall_q;
    end

endmodule : debounce_channel

// File: rtl/debounced_event_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// debounced_event_counter
// CHANNELS independent debounced inputs, each counting qualified edges in a
// WIDTH-bit counter that wraps (SATURATE=0) or holds at all-ones (SATURATE=1),
// with a sticky overflow flag per channel.
//
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-low reset
//   inp       in  [CHANNELS]        raw bouncy inputs
//   enable    in  global count enable (debouncing always runs)
//   edge_mode in  [2]               EDGE_NONE/RISE/FALL/BOTH for all channels
//   clear     in  [CHANNELS]        synchronous clear of count and overflow
//   level     out [CHANNELS]        debounced levels
//   out       out [CHANNELS*WIDTH]  counts, channel k at [k*WIDTH +: WIDTH]
//   overflow  out [CHANNELS]        sticky overflow flags
// -----------------------------------------------------------------------------
module debounced_event_counter
    import counter_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int SATURATE      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       inp,
    input  logic                      enable,
    input  logic [1:0]                edge_mode,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    edge_mode_e          mode;
    logic [CHANNELS-1:0] rise, fall, edge_hit;

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    assign mode = edge_mode_e'(edge_mode);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .inp   (inp[k]),
            .level (level[k]),
            .rise  (rise[k]),
            .fall  (fall[k])
        );

        // Mode is applied combinationally to the registered pulses, so changing
        // edge_mode alone can never create a pulse.
        assign edge_hit[k]               = edge_qualify(mode, rise[k], fall[k]);
        assign out[k*WIDTH +: WIDTH]     = cnt_q[k];
    end

    // Clear beats counting; an edge arriving with clear is dropped.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (clear[k]) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (edge_hit[k] && enable) begin
                if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end else begin
                    ovf_d[k] = 1'b1;
                    if (SATURATE == 0) begin
                        cnt_d[k] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;

endmodule : debounced_event_counter

// File: tb/tb_debounced_event_counter.sv
`timescale 1ns/1ps
// Self-checking bench: a wrapping and a saturating instance share stimulus and
// are compared against an event-level model (pending level per channel, edge
// counts computed with plain arithmetic once the input has settled).
module tb_debounced_event_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] inp = 2'b00;
    logic       enable = 1'b1;
    logic [1:0] edge_mode = EDGE_RISE;
    logic [1:0] clear = 2'b00;

    logic [1:0] lvl_w, lvl_s, ovf_w, ovf_s;
    logic [7:0] out_w, out_s;

    int  cw [2];
    int  cs [2];
    bit  ow [2];
    bit  os [2];
    bit  exp_lvl [2];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;

    always #20 clk = ~clk;

    debounced_event_counter #(.CHANNELS(2), .WIDTH(4), .STABLE_CYCLES(4),
                              .SYNC_STAGES(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .inp(inp), .enable(enable), .edge_mode(edge_mode),
        .clear(clear), .level(lvl_w), .out(out_w), .overflow(ovf_w));

    debounced_event_counter #(.CHANNELS(2), .WIDTH(4), .STABLE_CYCLES(4),
                              .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .inp(inp), .enable(enable), .edge_mode(edge_mode),
        .clear(clear), .level(lvl_s), .out(out_s), .overflow(ovf_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int ch = 0; ch < 2; ch++) begin
            check($sformatf("%s_lvl_w%0d", tag, ch), 32'(lvl_w[ch]), 32'(exp_lvl[ch]));
            check($sformatf("%s_lvl_s%0d", tag, ch), 32'(lvl_s[ch]), 32'(exp_lvl[ch]));
            check($sformatf("%s_cnt_w%0d", tag, ch), 32'(out_w[ch*4 +: 4]), 32'(cw[ch]));
            check($sformatf("%s_cnt_s%0d", tag, ch), 32'(out_s[ch*4 +: 4]), 32'(cs[ch]));
            check($sformatf("%s_ovf_w%0d", tag, ch), 32'(ovf_w[ch]), 32'(ow[ch]));
            check($sformatf("%s_ovf_s%0d", tag, ch), 32'(ovf_s[ch]), 32'(os[ch]));
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            cw[ch] = 0; cs[ch] = 0; ow[ch] = 0; os[ch] = 0; exp_lvl[ch] = 0;
        end
    endtask

    // One counted event: 4-bit wrap vs hold at 15, overflow on the event at 15.
    task automatic model_edge(input int ch);
        if (enable) begin
            if (cw[ch] == 15) begin ow[ch] = 1; cw[ch] = 0; end
            else cw[ch] = cw[ch] + 1;
            if (cs[ch] == 15) os[ch] = 1;
            else cs[ch] = cs[ch] + 1;
        end
    endtask

    task automatic model_level(input int ch, input bit v);
        if (v != exp_lvl[ch]) begin
            if ((v  && (edge_mode == EDGE_RISE || edge_mode == EDGE_BOTH)) ||
                (!v && (edge_mode == EDGE_FALL || edge_mode == EDGE_BOTH)))
                model_edge(ch);
            exp_lvl[ch] = v;
        end
    endtask

    // Long enough for sync + debounce window + count update, with margin.
    task automatic settle();
        repeat (14) @(negedge clk);
    endtask

    task automatic drive(input int ch, input bit v);
        @(negedge clk);
        inp[ch] = v;
        settle();
        model_level(ch, v);
    endtask

    // Short burst of toggles (dly=0 picks 3..8 ns per toggle), then hold v.
    task automatic burst_to(input int ch, input int n, input int dly, input bit v);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            inp[ch] = ~inp[ch];
            if (dly == 0) #($urandom_range(3, 8));
            else #(dly);
        end
        inp[ch] = v;
        settle();
        model_level(ch, v);
    endtask

    task automatic clear_pulse(input logic [1:0] mask);
        @(negedge clk);
        clear = mask;
        @(negedge clk);
        clear = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (mask[ch]) begin cw[ch] = 0; cs[ch] = 0; ow[ch] = 0; os[ch] = 0; end
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        int ch;

        // ---- Reset with inputs already high
        model_reset();
        inp = 2'b11;
        repeat (3) @(negedge clk);
        check_all("rst_hold");

        rst = 1'b1;
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (lvl_w[0]) begin n = i; break; end
        end
        check("rst_latency", 32'(n >= 6 && n <= 7), 32'd1);
        check("rst_no_edge_yet", 32'(out_w), 32'h00);
        @(posedge clk); #1;
        check("rst_first_rise_w", 32'(out_w), 32'h11);
        check("rst_first_rise_s", 32'(out_s), 32'h11);
        exp_lvl[0] = 1; exp_lvl[1] = 1;
        cw[0] = 1; cw[1] = 1; cs[0] = 1; cs[1] = 1;
        @(negedge clk);
        check_all("rst_release");

        // ---- Bounce rejection
        drive(0, 1'b0);
        clear_pulse(2'b01);
        check_all("pre_bounce");
        burst_to(0, 10, 5, 1'b1);
        check("bounce_one_rise", 32'(out_w[3:0]), 32'd1);
        check_all("bounce_rise");
        drive(0, 1'b0);
        burst_to(0, 10, 5, 1'b0);
        check_all("bounce_glitch");

        // ---- Edge modes on ch1
        clear_pulse(2'b10);
        @(negedge clk) edge_mode = EDGE_BOTH;
        for (int i = 0; i < 3; i++) begin drive(1, 1'b0); drive(1, 1'b1); end
        check("mode_both", 32'(out_w[7:4]), 32'd6);
        check_all("mode_both");
        @(negedge clk) edge_mode = EDGE_FALL;
        for (int i = 0; i < 3; i++) begin drive(1, 1'b0); drive(1, 1'b1); end
        check("mode_fall", 32'(out_w[7:4]), 32'd9);
        check_all("mode_fall");

        // ---- Wrap and saturate on ch0
        clear_pulse(2'b01);
        @(negedge clk) edge_mode = EDGE_RISE;
        for (int i = 0; i < 16; i++) begin drive(0, 1'b1); drive(0, 1'b0); end
        check("wrap_cnt", 32'(out_w[3:0]), 32'd0);
        check("wrap_ovf", 32'(ovf_w[0]), 32'd1);
        check("sat_cnt", 32'(out_s[3:0]), 32'd15);
        check("sat_ovf", 32'(ovf_s[0]), 32'd1);
        check_all("wrap16");
        drive(0, 1'b1);
        check_all("wrap17");

        // ---- Clear coincident with an edge pulse on ch0, ch1 edging too
        drive(0, 1'b0);
        drive(1, 1'b0);
        @(negedge clk);
        inp = 2'b11;
        for (int p = 1; p <= 6; p++) begin
            @(posedge clk); #1;
            if (p == 5) check("lat_before", 32'(lvl_w), 32'b00);
            if (p == 6) check("lat_at", 32'(lvl_w), 32'b11);
        end
        @(negedge clk) clear = 2'b01;
        @(posedge clk); #1;
        @(negedge clk) clear = 2'b00;
        cw[0] = 0; cs[0] = 0; ow[0] = 0; os[0] = 0;
        exp_lvl[0] = 1;
        model_level(1, 1'b1);
        settle();
        check("simul_cnt0", 32'(out_w[3:0]), 32'd0);
        check("simul_ovf0", 32'(ovf_w[0]), 32'd0);
        check_all("simul");

        // ---- Enable low: levels follow, counts freeze
        @(negedge clk) begin enable = 1'b0; edge_mode = EDGE_BOTH; end
        for (int i = 0; i < 2; i++) begin drive(1, 1'b0); drive(1, 1'b1); end
        check_all("enable_low");
        @(negedge clk) enable = 1'b1;

        // ---- Reset in the middle of a debounce window
        @(negedge clk) inp[0] = 1'b0;
        repeat (3) @(posedge clk);
        #5 rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid_check");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        settle();
        model_level(0, inp[0]);
        model_level(1, inp[1]);
        check_all("rst_mid_release");

        // ---- Randomised sequence
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                clear_pulse(2'($urandom_range(1, 3)));
            end else begin
                @(negedge clk);
                edge_mode = 2'($urandom_range(0, 3));
                enable    = ($urandom_range(0, 3) != 0);
                ch        = $urandom_range(0, 1);
                if (r < 4) burst_to(ch, $urandom_range(2, 8), 0, 1'($urandom_range(0, 1)));
                else       drive(ch, ~inp[ch]);
            end
            check_all($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_debounced_event_counter

// File: doc/debounced_event_counter.md
# debounced_event_counter

Multi-channel, parametrised successor to the single 4-bit bouncy-input counter. Each channel synchronises a raw asynchronous input, debounces it against a programmable stability window, and detects edges on the clean level (rising, falling or both). It then counts those edges in a WIDTH-bit counter that either wraps or saturates, with a sticky overflow flag. It sits between board-level switches/sensors and the register/display logic.

## Interface
- CHANNELS, 2: number of independent input channels (≥1).
- WIDTH, 4: counter width per channel (≥2).
- STABLE_CYCLES, 4: consecutive stable clocks required to accept a new level (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- SATURATE, 0: 0 = wrap at all-ones, 1 = hold at all-ones.
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk externally.
- inp  in  CHANNELS  raw asynchronous, bouncy inputs.
- enable  in  1  global count enable; debouncing continues when 0, counting does not.
- edge_mode  in  2  EDGE_NONE / EDGE_RISE / EDGE_FALL / EDGE_BOTH, applied to all channels.
- clear  in  CHANNELS  per-channel synchronous clear of count and overflow.
- level  out  CHANNELS  debounced level per channel.
- out  out  CHANNELS*WIDTH  counts, channel k at bits [k*WIDTH +: WIDTH].
- overflow  out  CHANNELS  sticky: set when a counted edge occurs with count at all-ones.

## Operation
- Reset (rst=0): synchroniser flops, level, debounce counters, out, overflow all 0. Per-channel FSM in STABLE.
- Synchroniser: SYNC_STAGES-flop chain per channel; `s` = last-stage output.
- Per-channel debounce FSM:
  - STABLE: s==level. On s!=level go to CHECK, debounce count = 1.
  - CHECK: if s==level, return to STABLE, count = 0 (glitch rejected). Else, if count==STABLE_CYCLES-1, toggle level, go to STABLE, count = 0. Else count+1.
  - STABLE_CYCLES=1 means a level is accepted on the first mismatching synchronised sample.
- Edge pulse (one clock): rise = level 0→1, fall = 1→0, qualified by edge_mode.
- Counter update per channel, priority order:
  - clear → out = 0, overflow = 0 (an edge in the same cycle is dropped).
  - edge & enable & out != all-ones → out + 1.
  - edge & enable & out == all-ones → overflow = 1; out = 0 if SATURATE=0, else it stays at all-ones.
- Channels are fully independent; simultaneous edges on several channels are all counted in the same cycle.
- edge_mode and enable are sampled in the cycle the edge pulse is present. A mode change never generates an edge.

## Timing
- Latency from a clean input transition to the level change: SYNC_STAGES + STABLE_CYCLES clocks, ±1 clock of sampling uncertainty.
- out updates 1 clock after the level changes.
- clear takes effect on the next rising edge. overflow is visible on the same edge as the wrapping or held count.
- Bounces shorter than STABLE_CYCLES synchronised clocks produce no level change and no count.
- Reset asserted mid-CHECK aborts immediately to reset values. No edge is produced on reset release, even if inp is already 1. That 0→1 level change is detected only after a full debounce window, and it counts as a rise.

## Structure
- Shared package `counter_pkg`: the edge_mode encodings EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11, plus the debounce FSM state constants.
- Sub-module `debounce_channel` (parameters SYNC_STAGES, STABLE_CYCLES; outputs level, rise, fall) is instantiated CHANNELS times by a generate loop.
- The top holds the edge qualification, the counters and the overflow flags.

## Test plan
Defaults apply (CHANNELS=2, WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2, SATURATE=0) with a 40 ns clk.
1. Reset: hold rst=0 with inp=2'b11 → out=0, level=0, overflow=0. Release → level[k]=1 after 6–7 clocks, out[k]=1 one clock later (edge_mode=RISE, enable=1).
2. Bounce rejection: toggle inp[0] every 5 ns for 50 ns, then hold it at 1 → exactly one rise, out[3:0]=1. Repeat with 10 toggles ending at 0 → out[3:0] unchanged.
3. Mode: edge_mode=BOTH with 3 clean pulses on ch1 (each held 500 ns) → out[7:4]=6. With edge_mode=FALL, 3 more pulses → 9.
4. Wrap and saturate: 16 clean rises on ch0 → out[3:0]=0, overflow[0]=1. With SATURATE=1 → out[3:0]=15, overflow[0]=1.
5. Simultaneous events: clear[0] asserted in the same cycle as an edge pulse on ch0, and ch1 also edging → out[3:0]=0, overflow[0]=0, out[7:4] incremented.
6. enable=0 during 2 clean pulses → level follows the input, counts unchanged. Assert rst=0 mid-CHECK → all outputs 0 immediately.
